// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling stage.
//   pool_type_e : pooling mode encoding (NONE/MAX/AVG; 3 is reserved)
//   state_e     : control FSM states
//   ACC_W       : accumulator width for a given element width and max kernel
//   log2_k      : log2 of a power-of-two kernel size (used for the AVG shift)
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_NONE = 2'd0,
    POOL_MAX  = 2'd1,
    POOL_AVG  = 2'd2
  } pool_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Room for the sum of KMAX*KMAX elements without overflow.
  function automatic int ACC_W(input int data_w, input int kmax);
    return data_w + 2 * $clog2(kmax);
  endfunction

  // Index of the highest set bit; exact for powers of two.
  function automatic logic [1:0] log2_k(input logic [2:0] k);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 3; i++)
      if (k[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/pool_window_ctr.sv
// Raster position tracking for the pooling stage.
//   clear/adv   : restart at (0,0) / step one accepted element
//   k, s, w, h  : latched kernel, stride, width, height
//   oc          : window column index (accumulator slot)
//   in_window   : current element lies inside a kernel window
//   first_elem  : current element is the top-left of its window
//   win_done    : current element is the bottom-right of its window
//   last_elem   : current element is (H-1, W-1)
// Phases wrap at S with compares only, so no division is needed.
module pool_window_ctr #(
  parameter int MAX_W = 32,
  parameter int WW    = $clog2(MAX_W) + 1,
  parameter int OW    = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          adv,
  input  logic [2:0]    k,
  input  logic [2:0]    s,
  input  logic [WW-1:0] w,
  input  logic [15:0]   h,
  output logic [OW-1:0] oc,
  output logic          in_window,
  output logic          first_elem,
  output logic          win_done,
  output logic          last_elem
);

  logic [WW-1:0] c;
  logic [15:0]   r;
  logic [2:0]    col_phase, row_phase;
  logic          end_of_row, col_wrap, row_wrap;

  assign end_of_row = (c == w - 1'b1);
  assign last_elem  = end_of_row && (r == h - 16'd1);
  assign col_wrap   = (col_phase == s - 3'd1);
  assign row_wrap   = (row_phase == s - 3'd1);

  assign in_window  = (col_phase < k) && (row_phase < k);
  assign first_elem = (col_phase == 3'd0) && (row_phase == 3'd0);
  // Partial windows at the right/bottom edge never reach K-1 in both phases.
  assign win_done   = (col_phase == k - 3'd1) && (row_phase == k - 3'd1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      c         <= '0;
      r         <= '0;
      oc        <= '0;
      col_phase <= '0;
      row_phase <= '0;
    end else if (adv) begin
      if (end_of_row) begin
        c         <= '0;
        oc        <= '0;
        col_phase <= '0;
        if (last_elem) begin
          r         <= '0;
          row_phase <= '0;
        end else begin
          r         <= r + 16'd1;
          row_phase <= row_wrap ? 3'd0 : row_phase + 3'd1;
        end
      end else begin
        c         <= c + 1'b1;
        col_phase <= col_wrap ? 3'd0 : col_phase + 3'd1;
        if (col_wrap) oc <= oc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_engine.sv
// Streaming pooling stage (NONE / MAX / AVG) between the activation array
// and the output SRAM writer.
//   start, cfg_*         : per-frame config, latched on an accepted start
//   in_valid/in_ready    : raster-order element input
//   out_valid/out_ready  : raster-order pooled output, full backpressure
//   busy                 : frame in progress (RUN or FLUSH)
//   done                 : one-cycle pulse after the last output drains
//   cfg_err              : one-cycle pulse when start carries a bad config
// One output register; in_ready drops only when it is full and stalled, so
// a result consumed and replaced in the same cycle costs no bubble.
module pool_engine
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 32,
  parameter int KMAX   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 cfg_type,
  input  logic [2:0]                 cfg_k,
  input  logic [2:0]                 cfg_s,
  input  logic [$clog2(MAX_W):0]     cfg_w,
  input  logic [15:0]                cfg_h,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int WW = $clog2(MAX_W) + 1;
  localparam int OW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int AW = ACC_W(DATA_W, KMAX);

  state_e        state, state_nx;
  pool_type_e    type_q;
  logic [2:0]    k_q, s_q;
  logic [2:0]    shift_q;
  logic [WW-1:0] w_q;
  logic [15:0]   h_q;

  logic          cfg_ok, launch, accept, emit, acc_we;
  logic [OW-1:0] oc;
  logic          in_window, first_elem, win_done, last_elem;

  logic [AW-1:0] acc [MAX_W];
  logic [AW-1:0] x_ext, acc_rd, combined, avg_val;
  logic [DATA_W-1:0] result;

  // ---------------- config check ----------------
  always_comb begin
    cfg_ok = 1'b1;
    if (cfg_type == 2'd3) cfg_ok = 1'b0;
    if (cfg_w == '0 || cfg_w > WW'(MAX_W)) cfg_ok = 1'b0;
    if (cfg_h == '0) cfg_ok = 1'b0;
    // Pass-through ignores K and S entirely.
    if (cfg_type != 2'(POOL_NONE)) begin
      if (cfg_k == 3'd0 || cfg_s == 3'd0 || cfg_k > 3'(KMAX) || cfg_s < cfg_k)
        cfg_ok = 1'b0;
      if (cfg_type == 2'(POOL_AVG) && (cfg_k & (cfg_k - 3'd1)) != 3'd0)
        cfg_ok = 1'b0;
    end
  end

  // A start landing on the done cycle is dropped.
  assign launch   = (state == ST_IDLE) && start && !done;
  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (launch && cfg_ok) state_nx = ST_RUN;
      ST_RUN:   if (accept && last_elem) state_nx = ST_FLUSH;
      ST_FLUSH: if (!out_valid || out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      done    <= (state == ST_FLUSH) && (state_nx == ST_IDLE);
      cfg_err <= launch && !cfg_ok;
    end
  end

  // Pass-through runs with K=S=1 so every element is its own window.
  always_ff @(posedge clock) begin
    if (reset) begin
      type_q  <= POOL_NONE;
      k_q     <= 3'd1;
      s_q     <= 3'd1;
      shift_q <= 3'd0;
      w_q     <= '0;
      h_q     <= '0;
    end else if (launch && cfg_ok) begin
      type_q  <= pool_type_e'(cfg_type);
      w_q     <= cfg_w;
      h_q     <= cfg_h;
      shift_q <= {log2_k(cfg_k), 1'b0};
      if (cfg_type == 2'(POOL_NONE)) begin
        k_q <= 3'd1;
        s_q <= 3'd1;
      end else begin
        k_q <= cfg_k;
        s_q <= cfg_s;
      end
    end
  end

  // ---------------- position tracking ----------------
  pool_window_ctr #(.MAX_W(MAX_W), .WW(WW), .OW(OW)) u_ctr (
    .clock      (clock),
    .reset      (reset),
    .clear      (launch && cfg_ok),
    .adv        (accept),
    .k          (k_q),
    .s          (s_q),
    .w          (w_q),
    .h          (h_q),
    .oc         (oc),
    .in_window  (in_window),
    .first_elem (first_elem),
    .win_done   (win_done),
    .last_elem  (last_elem)
  );

  // ---------------- datapath ----------------
  assign x_ext  = AW'(in_data);
  assign acc_rd = acc[oc];

  always_comb begin
    combined = x_ext;
    if (!first_elem) begin
      if (type_q == POOL_MAX) combined = (x_ext > acc_rd) ? x_ext : acc_rd;
      else                    combined = acc_rd + x_ext;
    end
  end

  assign avg_val = combined >> shift_q;

  always_comb begin
    case (type_q)
      POOL_AVG: result = avg_val[DATA_W-1:0];
      POOL_MAX: result = combined[DATA_W-1:0];
      default:  result = in_data;
    endcase
  end

  assign acc_we = accept && in_window && (type_q != POOL_NONE);
  assign emit   = accept && ((type_q == POOL_NONE) || (in_window && win_done));

  // First-use overwrite makes an accumulator reset unnecessary.
  always_ff @(posedge clock) begin
    if (acc_we) acc[oc] <= combined;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
module tb_pool_engine;
  localparam int DATA_W = 16;
  localparam int MAX_W  = 32;
  localparam int WW     = $clog2(MAX_W) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        cfg_type = '0;
  logic [2:0]        cfg_k = '0, cfg_s = '0;
  logic [WW-1:0]     cfg_w = '0;
  logic [15:0]       cfg_h = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              busy, done, cfg_err;

  int compared = 0, mismatched = 0;
  int exp_q[$];
  int got_q[$];
  int rmode = 0;       // 0: always ready, 1: toggle, 2: random
  int last_iters = 0;
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d = '0;

  always #5 clock = ~clock;

  pool_engine #(.DATA_W(DATA_W), .MAX_W(MAX_W), .KMAX(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_type(cfg_type), .cfg_k(cfg_k), .cfg_s(cfg_s), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: pooled outputs straight from window geometry.
  task automatic model(input int typ, k, s, w, h, input int d[$], output int res[$]);
    res = {};
    if (typ == 0) begin
      foreach (d[i]) res.push_back(d[i]);
    end else begin
      for (int wr = 0; wr * s + k <= h; wr++)
        for (int wc = 0; wc * s + k <= w; wc++) begin
          int sum = 0, mx = 0, v;
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              v = d[(wr * s + dy) * w + wc * s + dx];
              sum += v;
              if (v > mx) mx = v;
            end
          res.push_back(typ == 1 ? mx : sum / (k * k));
        end
    end
  endtask

  task automatic cmp_list(input string name, input int got[$], input int lit[$]);
    check({name, "_count"}, got.size(), lit.size());
    foreach (lit[i])
      if (i < got.size()) check(name, got[i], lit[i]);
  endtask

  // Output-side compare: every transfer, stall stability, stall in_ready.
  always @(negedge clock) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, hold_d);
      end
      if (out_valid && !out_ready) check("in_ready_while_stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_data));
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got %0d required none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic do_start(input int typ, k, s, w, h);
    cfg_type = 2'(typ); cfg_k = 3'(k); cfg_s = 3'(s); cfg_w = WW'(w); cfg_h = 16'(h);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int d[$], input int n, input bit gaps);
    int i = 0, guard = 0;
    bit took;
    while (i < n && guard < 20000) begin
      if (gaps && $urandom_range(3) == 0) in_valid = 1'b0;
      else begin in_valid = 1'b1; in_data = DATA_W'(d[i]); end
      @(negedge clock);
      took = in_valid && in_ready;
      @(posedge clock); #1;
      if (took) i++;
      guard++;
    end
    in_valid = 1'b0;
    last_iters = guard;
    if (i < n) begin
      compared++;
      mismatched++;
      $display("FAIL input_timeout: accepted %0d required %0d", i, n);
    end
  endtask

  task automatic run_frame(input int typ, k, s, w, h, input int d[$], input bit gaps,
                           input bit start_on_done, output int res[$]);
    int m[$];
    int guard = 0;
    bit seen = 0;
    model(typ, k, s, w, h, d, m);
    foreach (m[j]) exp_q.push_back(m[j]);
    got_q.delete();
    do_start(typ, k, s, w, h);
    check("busy_after_start", busy, 1);
    drive(d, d.size(), gaps);
    while (!seen && guard < 2000) begin
      if (done) seen = 1;
      else begin @(posedge clock); #1; guard++; end
    end
    check("done_seen", seen, 1);
    if (start_on_done && seen) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_idle_after_done", busy, 0);
    check("outputs_pending", exp_q.size(), 0);
    res = got_q;
  endtask

  task automatic try_bad(input string name, input int typ, k, s, w, h);
    do_start(typ, k, s, w, h);
    check({name, "_cfg_err"}, cfg_err, 1);
    check({name, "_busy"}, busy, 0);
    @(posedge clock); #1;
    check({name, "_pulse_end"}, cfg_err, 0);
  endtask

  initial begin
    int d4[$], d5[$], m[$], g[$], rd[$];
    int typ, k, s, w, h;

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++) d4.push_back(i);
    for (int i = 0; i < 25; i++) d5.push_back(i);

    // Pin the model to hand-computed results.
    model(1, 2, 2, 4, 4, d4, m); cmp_list("model_max", m, '{5, 7, 13, 15});
    model(2, 2, 2, 4, 4, d4, m); cmp_list("model_avg", m, '{2, 4, 10, 12});
    model(1, 2, 3, 5, 5, d5, m); cmp_list("model_max_s3", m, '{6, 9, 21, 24});

    rmode = 0;
    run_frame(1, 2, 2, 4, 4, d4, 0, 0, g); cmp_list("dir_max", g, '{5, 7, 13, 15});
    run_frame(2, 2, 2, 4, 4, d4, 0, 0, g); cmp_list("dir_avg", g, '{2, 4, 10, 12});
    run_frame(0, 0, 0, 4, 4, d4, 0, 0, g);
    cmp_list("dir_none", g, d4);
    check("none_full_rate_cycles", last_iters, 16);
    run_frame(1, 2, 3, 5, 5, d5, 0, 1, g); cmp_list("dir_max_s3", g, '{6, 9, 21, 24});
    rmode = 1;
    run_frame(1, 2, 2, 4, 4, d4, 0, 0, g); cmp_list("dir_max_toggle", g, '{5, 7, 13, 15});
    rmode = 0;
    @(posedge clock); #1;

    try_bad("avg_k3", 2, 3, 3, 4, 4);
    try_bad("s_lt_k", 1, 2, 1, 4, 4);
    try_bad("type3", 3, 2, 2, 4, 4);
    try_bad("w_too_big", 0, 1, 1, 33, 4);
    try_bad("h_zero", 1, 2, 2, 4, 0);

    // Abort mid-frame: only the first window completes before reset.
    exp_q.push_back(5);
    got_q.delete();
    do_start(1, 2, 2, 4, 4);
    drive(d4, 7, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cfg_err", cfg_err, 0);
    check("abort_seen_first", got_q.size(), 1);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clock); #1;
    run_frame(1, 2, 2, 4, 4, d4, 0, 0, g); cmp_list("after_abort", g, '{5, 7, 13, 15});

    // Randomized frames with input gaps and random backpressure.
    rmode = 2;
    for (int f = 0; f < 25; f++) begin
      typ = $urandom_range(2);
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 8);
      if (typ == 0) begin
        k = $urandom_range(7); s = $urandom_range(7);
      end else begin
        k = (typ == 2) ? (1 << $urandom_range(2)) : $urandom_range(1, 4);
        s = $urandom_range(k, 7);
      end
      rd = {};
      for (int i = 0; i < w * h; i++) rd.push_back(int'($urandom_range(65535)));
      run_frame(typ, k, s, w, h, rd, 1, 0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
# pool_engine

Streaming, parametrised pooling stage between the activation-function array and the output SRAM writer. It accepts activation elements one per cycle in raster order under valid/ready, and performs NONE (pass-through), MAX or AVG pooling. Kernel size, stride and frame dimensions are set per frame at run time. Pooled results are emitted in raster order under valid/ready with full backpressure support.

## Interface
Parameters:
- DATA_W, 16: element width, unsigned; equals OUT_BIN_LEN.
- MAX_W, 32: maximum frame width in elements.
- KMAX, 4: maximum kernel size.

Ports:
- clock  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches the config and begins a frame; ignored unless IDLE.
- cfg_type  in  2  0=NONE, 1=MAX, 2=AVG, 3=reserved (invalid).
- cfg_k  in  3  kernel size K.
- cfg_s  in  3  stride S.
- cfg_w  in  clog2(MAX_W)+1  frame width W.
- cfg_h  in  16  frame height H.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  DATA_W  activation element.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  DATA_W  pooled element.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start with a valid config.
  - RUN -> FLUSH when the element at (H-1, W-1) is accepted.
  - FLUSH -> IDLE when the output register is empty or being consumed that cycle; done pulses on that transition.
- Config is invalid, and start is rejected with a cfg_err pulse while staying IDLE, for any of: type=3; K=0; S=0; K>KMAX; S<K; W=0; W>MAX_W; H=0; AVG with K not a power of two. In NONE mode K and S are not checked.
- Counters: column c, col_phase (c mod S), window column index oc, row r, row_phase (r mod S). All advance only on an accepted input, with no division logic.
- An element is in-window iff col_phase<K and row_phase<K; out-of-window elements are consumed and dropped.
- Accumulator array acc[0..MAX_W-1], width DATA_W+2*clog2(KMAX), indexed by oc.
  - First window element (row_phase=0, col_phase=0) overwrites acc[oc].
  - Otherwise MAX takes max(acc, x) and AVG takes acc + x.
- Window completes on the accepted element with row_phase=K-1 and col_phase=K-1.
  - out_data takes the combined value; for AVG it is shifted right by 2*log2(K), truncating.
  - A right-edge or bottom-edge partial window never completes and never emits.
- NONE: every accepted element is emitted unchanged.
- Unsigned compare and add throughout; AVG cannot overflow given the accumulator width.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, cfg_err=0, state IDLE, all counters 0.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; full throughput, 1 element/cycle.
- Latency: an input accepted at cycle t that completes a window (or any input in NONE mode) gives out_valid=1 at t+1.
- out_valid/out_data hold stable until out_ready; acceptance with out_ready in the same cycle as a new result reloads the register with no bubble.
- cfg_err and done pulse the cycle after the triggering condition is met.
- A start in the same cycle as done is ignored.
- Reset mid-frame aborts immediately: outputs go to reset values, no done pulse, pending output lost. acc contents are don't-care because they are overwritten on first use.

## Structure
- Shared package pool_pkg holds:
  - the pool_type_e enum (POOL_NONE, POOL_MAX, POOL_AVG); POOL_NONE/POOL_MAX encodings match the existing `define values;
  - the state_e enum;
  - the ACC_W function.
- One sub-module, pool_window_ctr: the col/row phase and index counters with in-window, window-complete and last-element flags.

## Test plan
- 4x4 frame, values 0..15 raster order, MAX K=2 S=2 -> outputs 5, 7, 13, 15, then done.
- Same frame, AVG K=2 S=2 -> outputs 2, 4, 10, 12.
- Same frame, NONE -> 16 outputs 0..15 in order with in_valid held high, one per cycle after 1-cycle latency.
- 5x5 frame, values 0..24, MAX K=2 S=3 -> outputs 6, 9, 21, 24; row/column 2 dropped; total 4 outputs.
- MAX K=2 S=2 on the 4x4 frame with out_ready toggling 1010… -> out_data held stable while stalled, no lost or duplicated outputs, and in_ready low whenever out_valid=1 and out_ready=0.
- Config and reset cases:
  - start with AVG K=3 -> cfg_err pulse, busy stays 0.
  - start with S=1 K=2 -> cfg_err.
  - reset after 7 inputs -> all outputs at reset values next cycle; a fresh frame afterwards is correct.
